// File: rtl/cpsr_flag_unit.sv
// cpsr_flag_unit: architectural CPSR plus one saved SPSR for the ARM core.
// Accepts flag results from the ALU stage, MSR writes, exception entry and
// exception return, resolved by a fixed priority each cycle.  Exposes the
// registered flags in condition-checker order and a zero-latency forwarded
// copy of the flags that the next edge will register.
module cpsr_flag_unit #(
   parameter logic [4:0] RESET_MODE = 5'b10011,
   parameter logic [4:0] FIQ_MODE   = 5'b10001,
   parameter logic [4:0] USER_MODE  = 5'b10000
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        STALL,
   input  logic        ALU_VALID,
   input  logic        SET_FLAGS,
   input  logic        COND_PASS,
   input  logic        LOGIC_OP,
   input  logic [31:0] ALU_RESULT,
   input  logic        ALU_C,
   input  logic        ALU_V,
   input  logic        SHIFT_C,
   input  logic        MSR_WE,
   input  logic        MSR_SPSR,
   input  logic [1:0]  MSR_MASK,
   input  logic [31:0] MSR_DATA,
   input  logic        EXC_ENTRY,
   input  logic [4:0]  EXC_MODE,
   input  logic        EXC_RETURN,
   output logic [31:0] CPSR,
   output logic [31:0] SPSR,
   output logic [3:0]  FLAGS,
   output logic [3:0]  FLAGS_NXT
);

   // Implemented bits: NZCV [31:28], I [7], F [6], mode [4:0].  T [5] stays 0.
   localparam logic [31:0] FLAG_MASK = 32'hF000_0000;
   localparam logic [31:0] CTRL_MASK = 32'h0000_00DF;
   localparam logic [31:0] IMPL_MASK = FLAG_MASK | CTRL_MASK;
   localparam logic [31:0] RESET_CPSR = 32'h0000_00C0 | {27'd0, RESET_MODE};

   logic [31:0] cpsr_q, cpsr_d;
   logic [31:0] spsr_q, spsr_d;
   logic        flag_upd;
   logic [3:0]  nzcv_alu;
   logic [31:0] msr_bits;

   // Reorder an {N,Z,C,V} nibble into the checker's {V,C,Z,N} order.
   function automatic logic [3:0] to_cond_order(input logic [3:0] nzcv);
      return {nzcv[0], nzcv[1], nzcv[2], nzcv[3]};
   endfunction

   // Replace the bits selected by sel with the corresponding bits of data.
   function automatic logic [31:0] merge_bits(input logic [31:0] old_v,
                                              input logic [31:0] data,
                                              input logic [31:0] sel);
      return (old_v & ~sel) | (data & sel);
   endfunction

   // Next-state selection: one update source per cycle, highest priority wins.
   always_comb begin
      cpsr_d   = cpsr_q;
      spsr_d   = spsr_q;
      flag_upd = ALU_VALID & SET_FLAGS & COND_PASS;
      nzcv_alu = {ALU_RESULT[31],
                  (ALU_RESULT == 32'd0),
                  (LOGIC_OP ? SHIFT_C : ALU_C),
                  (LOGIC_OP ? cpsr_q[28] : ALU_V)};
      msr_bits = ({32{MSR_MASK[1]}} & FLAG_MASK) | ({32{MSR_MASK[0]}} & CTRL_MASK);

      if (STALL) begin
         cpsr_d = cpsr_q;
      end else if (EXC_ENTRY) begin
         // SPSR takes the registered CPSR, so a concurrent flag result is lost.
         spsr_d      = cpsr_q;
         cpsr_d[4:0] = EXC_MODE;
         cpsr_d[7]   = 1'b1;
         if (EXC_MODE == FIQ_MODE) begin
            cpsr_d[6] = 1'b1;
         end
      end else if (EXC_RETURN) begin
         cpsr_d = spsr_q;
      end else if (MSR_WE) begin
         if (MSR_SPSR) begin
            spsr_d = merge_bits(spsr_q, MSR_DATA, msr_bits);
         end else if (cpsr_q[4:0] == USER_MODE) begin
            // User code may change the flags but not its own mode or masks.
            cpsr_d = merge_bits(cpsr_q, MSR_DATA, msr_bits & FLAG_MASK);
         end else begin
            cpsr_d = merge_bits(cpsr_q, MSR_DATA, msr_bits);
         end
      end else if (flag_upd) begin
         cpsr_d[31:28] = nzcv_alu;
      end
   end

   // State registers with synchronous active-low reset; unimplemented bits held at 0.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         cpsr_q <= RESET_CPSR;
         spsr_q <= 32'd0;
      end else begin
         cpsr_q <= cpsr_d & IMPL_MASK;
         spsr_q <= spsr_d & IMPL_MASK;
      end
   end

   assign CPSR      = cpsr_q;
   assign SPSR      = spsr_q;
   assign FLAGS     = to_cond_order(cpsr_q[31:28]);
   // Forwarded flags: what the next edge registers, zero while reset is asserted.
   assign FLAGS_NXT = RESET_N ? to_cond_order(cpsr_d[31:28]) : 4'b0000;

endmodule

// File: doc/cpsr_flag_unit.md
# cpsr_flag_unit

Architectural status register for the ARM core. Holds CPSR (NZCV flags, I/F disables, mode) and one saved SPSR. Takes flag results from the ALU stage, MSR writes, exception entry and exception return. Drives the 4-bit flag vector that the condition checker evaluates against each instruction's condition field, plus a same-cycle forwarded copy for back-to-back flag-setting instructions.

## Interface
Parameters
- RESET_MODE, 5'b10011: mode field loaded at reset (supervisor).
- FIQ_MODE, 5'b10001: mode code for which exception entry also sets F.
- USER_MODE, 5'b10000: mode code in which MSR control-byte writes are ignored.

Ports
- CLK  in  1  single clock; all state changes on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- STALL  in  1  freezes all state; every update input is ignored while high.
- ALU_VALID  in  1  an ALU result is present this cycle.
- SET_FLAGS  in  1  instruction S bit.
- COND_PASS  in  1  condition-check result for that instruction.
- LOGIC_OP  in  1  1 = logical op: C from SHIFT_C, V preserved.
- ALU_RESULT  in  32  ALU result.
- ALU_C  in  1  adder carry-out.
- ALU_V  in  1  adder overflow.
- SHIFT_C  in  1  barrel-shifter carry-out.
- MSR_WE  in  1  MSR write strobe.
- MSR_SPSR  in  1  1 = target SPSR, 0 = target CPSR.
- MSR_MASK  in  2  bit1 = flags field [31:28], bit0 = control byte [7:0].
- MSR_DATA  in  32  MSR source operand.
- EXC_ENTRY  in  1  exception taken this cycle.
- EXC_MODE  in  5  mode entered on exception.
- EXC_RETURN  in  1  restore CPSR from SPSR.
- CPSR  out  32  registered CPSR.
- SPSR  out  32  registered SPSR.
- FLAGS  out  4  registered flags, condition-checker order: [0]=N, [1]=Z, [2]=C, [3]=V.
- FLAGS_NXT  out  4  combinational next-cycle flags, same bit order.

## Operation
- CPSR layout: [31]=N, [30]=Z, [29]=C, [28]=V, [7]=I, [6]=F, [5]=T (always 0), [4:0]=mode. All other bits read 0 and are never written.
- Update sources are mutually exclusive by priority:
  - RESET_N low, then
  - STALL, then
  - EXC_ENTRY, then
  - EXC_RETURN, then
  - MSR_WE, then
  - flag update.
- Only the highest-priority active source takes effect. All lower-priority sources in that cycle are discarded.
- Flag update: fires when ALU_VALID & SET_FLAGS & COND_PASS.
  - N = ALU_RESULT[31].
  - Z = (ALU_RESULT == 0).
  - C = LOGIC_OP ? SHIFT_C : ALU_C.
  - V = LOGIC_OP ? old V : ALU_V.
  - I/F/mode are unchanged.
- MSR write: MSR_MASK[1] writes bits [31:28] from MSR_DATA. MSR_MASK[0] writes bits [7:6] and [4:0], and is ignored for the CPSR target when the current mode = USER_MODE. With MSR_MASK=0 nothing changes.
- Exception entry: SPSR <= current registered CPSR; mode <= EXC_MODE; I <= 1; F <= 1 if EXC_MODE = FIQ_MODE, otherwise F is unchanged; flags unchanged.
- Exception return: CPSR <= SPSR (all implemented bits); SPSR unchanged.
- FLAGS is always CPSR[31:28] reordered to {V,C,Z,N}.
- FLAGS_NXT equals the flag nibble that will be registered at the next edge, given the current inputs. While STALL is high it equals FLAGS.

## Timing
- Reset (RESET_N low at an edge):
  - CPSR = 32'h000000C0 | RESET_MODE (32'h000000D3 with defaults).
  - SPSR = 0.
  - FLAGS = 0.
  - Reset overrides every other input, including mid-exception entry.
- Latency: every update is visible on CPSR/SPSR/FLAGS one cycle after the qualifying edge. FLAGS_NXT has zero latency, so the condition checker can use it for the immediately following instruction.
- A stall held for any number of cycles leaves all outputs constant. The update presented on the cycle STALL drops is applied normally.
- Simultaneous EXC_ENTRY and flag update: the flag update is lost, and SPSR captures the pre-update flags.
- Simultaneous EXC_RETURN and MSR_WE: MSR is dropped.
- MSR write to SPSR in the same cycle as a flag update: MSR wins and CPSR flags are unchanged. This is deliberate: one instruction per cycle, so the case only arises when a flush is pending.

## Test plan
- Reset, then idle: CPSR=32'h000000D3, SPSR=0, FLAGS=4'b0000.
- ADDS result 0 with ALU_C=1, ALU_V=0, COND_PASS=1: next cycle FLAGS=4'b0110 and CPSR[31:28]=4'b0110. FLAGS_NXT=4'b0110 in the issuing cycle.
- Flag update with COND_PASS=0, then SET_FLAGS=0, then STALL=1: FLAGS is unchanged in all three cases. Then an ANDS with result 32'h80000000, SHIFT_C=1 and prior V=1 gives FLAGS=4'b1101.
- MSR in user mode (CPSR mode=10000) with MSR_MASK=2'b11 and MSR_DATA=32'hF00000D3: flags become 4'hF, and mode stays 10000 with I/F unchanged.
- EXC_ENTRY with EXC_MODE=10001 while CPSR=32'h60000010 and a concurrent flag update: SPSR=32'h60000010 and CPSR=32'h600000D1. EXC_RETURN on the next cycle restores CPSR=32'h60000010.
- Assert RESET_N low in the same cycle as EXC_ENTRY: outputs return to reset values and SPSR=0.
